// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types: words, instruction names, stage registers, memory FSM states
package rv32i_types;

    typedef logic [31:0] word;

    typedef enum logic [5:0] {
        NOP_I, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } instr_name_e;

    typedef struct packed {
        logic        valid;
        word         alu_result;
        logic [4:0]  rd;
        logic        wbv;
        instr_name_e decoded_instr_name;
        word         store_data;
        logic        is_load;
        word         pc_plus_4;
        word         instruction;
    } exmem_reg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        wbv;
        word         result;
        instr_name_e decoded_instr_name;
        word         pc_plus_4;
        word         instruction;
    } memwb_reg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_e;

    function automatic logic is_mem_instr(input instr_name_e name);
        return (name inside {LB, LH, LW, LBU, LHU, SB, SH, SW});
    endfunction

    function automatic logic is_store_instr(input instr_name_e name);
        return (name inside {SB, SH, SW});
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data-memory request/response port between the memory stage and data memory
interface memory_stage_if;

    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

endinterface

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering for loads/stores; misalignment flag only when
// MEM_STAGE_MISALIGN_CHECK_EN is defined
module load_store_align
    import rv32i_types::*;
(
    input  instr_name_e instr_name,
    input  logic [1:0]  off,
    input  word         store_data,
    input  word         rdata,
    output logic [3:0]  be,
    output word         wdata,
    output word         load_result,
    output logic        misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte = rdata[{off, 3'b000} +: 8];
        rhalf = rdata[{off[1], 4'b0000} +: 16];
        case (instr_name)
            LB:      load_result = {{24{rbyte[7]}}, rbyte};
            LBU:     load_result = {24'h0, rbyte};
            LH:      load_result = {{16{rhalf[15]}}, rhalf};
            LHU:     load_result = {16'h0, rhalf};
            default: load_result = rdata;
        endcase
    end

    // Store data is replicated into every lane so the enables alone pick the target bytes.
    always_comb begin
        case (instr_name)
            SB: begin
                be    = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end
            SH: begin
                be    = 4'b0011 << {off[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'hF;
                wdata = store_data;
            end
        endcase
    end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    always_comb begin
        case (instr_name)
            LH, LHU, SH: misaligned = off[0];
            LW, SW:      misaligned = (off != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - load/store pipeline stage with IDLE/REQ/WAIT access FSM and wait timeout;
// misaligned accesses are rejected when MEM_STAGE_MISALIGN_CHECK_EN is defined
module memory_stage
    import rv32i_types::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  exmem_reg              EXMEM,
    output memwb_reg              MEMWB,
    output logic                  stall_flag,
    output logic                  mem_error,
    memory_stage_if.master        dmem
);

    localparam int CW = $clog2(MAX_WAIT) + 1;

    mem_state_e    state;
    logic [CW-1:0] wait_cnt;

    logic [3:0]    align_be;
    word           align_wdata;
    word           load_result;
    logic          misaligned;

    logic          mem_op;
    logic          store_op;
    logic          idle_issue;
    logic          store_accept;
    logic          at_limit;
    logic          timeout;
    logic          req_valid;
    logic          unused_is_load;

    load_store_align u_align (
        .instr_name  (EXMEM.decoded_instr_name),
        .off         (EXMEM.alu_result[1:0]),
        .store_data  (EXMEM.store_data),
        .rdata       (dmem.dmem_rdata),
        .be          (align_be),
        .wdata       (align_wdata),
        .load_result (load_result),
        .misaligned  (misaligned)
    );

    // Load/store is decided from the decoded name; the precomputed flag is redundant here.
    assign unused_is_load = EXMEM.is_load;

    assign mem_op       = EXMEM.valid && is_mem_instr(EXMEM.decoded_instr_name);
    assign store_op     = is_store_instr(EXMEM.decoded_instr_name);
    assign idle_issue   = mem_op && !misaligned;
    assign store_accept = dmem.dmem_req_ready && store_op;
    assign at_limit     = (wait_cnt == CW'(MAX_WAIT - 1));
    assign timeout      = ((state == REQ)  && at_limit && !store_accept) ||
                          ((state == WAIT) && at_limit && !dmem.dmem_rsp_valid);

    always_comb begin
        req_valid  = 1'b0;
        stall_flag = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    req_valid  = idle_issue;
                    stall_flag = idle_issue && !store_accept;
                end
                REQ: begin
                    req_valid  = 1'b1;
                    stall_flag = !store_accept && !timeout;
                end
                WAIT: begin
                    stall_flag = !dmem.dmem_rsp_valid && !timeout;
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_req_valid = req_valid;
    assign dmem.dmem_addr      = {EXMEM.alu_result[31:2], 2'b00};
    assign dmem.dmem_we        = store_op;
    assign dmem.dmem_be        = align_be;
    assign dmem.dmem_wdata     = align_wdata;

    function automatic memwb_reg make_memwb(input exmem_reg ex, input word result, input logic wbv);
        memwb_reg m;
        m.valid              = 1'b1;
        m.rd                 = ex.rd;
        m.wbv                = wbv;
        m.result             = result;
        m.decoded_instr_name = ex.decoded_instr_name;
        m.pc_plus_4          = ex.pc_plus_4;
        m.instruction        = ex.instruction;
        return m;
    endfunction

    // Every path that does not retire an instruction leaves MEMWB.valid low (bubble).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            MEMWB     <= '0;
            mem_error <= 1'b0;
        end else begin
            mem_error   <= 1'b0;
            MEMWB.valid <= 1'b0;
            wait_cnt    <= wait_cnt + 1'b1;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (EXMEM.valid && !mem_op) begin
                        MEMWB <= make_memwb(EXMEM, EXMEM.alu_result, EXMEM.wbv);
                    end else if (mem_op && misaligned) begin
                        mem_error <= 1'b1;
                    end else if (mem_op) begin
                        if (store_accept) begin
                            MEMWB <= make_memwb(EXMEM, EXMEM.alu_result, 1'b0);
                        end else if (dmem.dmem_req_ready) begin
                            state <= WAIT;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (store_accept) begin
                        MEMWB <= make_memwb(EXMEM, EXMEM.alu_result, 1'b0);
                        state <= IDLE;
                    end else if (timeout) begin
                        mem_error <= 1'b1;
                        state     <= IDLE;
                    end else if (dmem.dmem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_rsp_valid) begin
                        MEMWB <= make_memwb(EXMEM, load_result, EXMEM.wbv);
                        state <= IDLE;
                    end else if (timeout) begin
                        mem_error <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;
    import rv32i_types::*;

    logic     clk;
    logic     reset;
    exmem_reg ex;
    memwb_reg wb;
    logic     stall_flag;
    logic     mem_error;
    int       total;
    int       bad;

    memory_stage_if dmem();

    memory_stage #(.MAX_WAIT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .EXMEM      (ex),
        .MEMWB      (wb),
        .stall_flag (stall_flag),
        .mem_error  (mem_error),
        .dmem       (dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ex(input instr_name_e name, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] rd, input logic wbv, input logic is_load);
        ex                    = '0;
        ex.valid              = 1'b1;
        ex.decoded_instr_name = name;
        ex.alu_result         = alu;
        ex.store_data         = sd;
        ex.rd                 = rd;
        ex.wbv                = wbv;
        ex.is_load            = is_load;
        ex.pc_plus_4          = 32'h0000_0104;
        ex.instruction        = 32'h0000_0013;
    endtask

    task automatic set_mem(input logic ready, input logic rsp, input logic [31:0] rdata);
        dmem.dmem_req_ready = ready;
        dmem.dmem_rsp_valid = rsp;
        dmem.dmem_rdata     = rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_ex(LW, 32'h0000_1000, 32'h0, 5'd1, 1'b1, 1'b1);
        set_mem(1'b1, 1'b0, 32'h0);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        total++; if (stall_flag !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_flag); end
        total++; if (dmem.dmem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", dmem.dmem_req_valid); end
        total++; if (wb.valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b want=0", wb.valid); end
        total++; if (wb.result !== 32'h0) begin bad++; $display("FAIL reset_wb_result got=%h want=0", wb.result); end
        total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL reset_mem_error got=%0b want=0", mem_error); end
        @(negedge clk);
        reset = 1'b1;
        ex = '0;
        set_mem(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_nonmem();
        @(negedge clk);
        set_ex(ADDI, 32'h0000_0005, 32'h0, 5'd3, 1'b1, 1'b0);
        #1;
        total++; if (stall_flag !== 1'b0) begin bad++; $display("FAIL addi_stall got=%0b want=0", stall_flag); end
        total++; if (dmem.dmem_req_valid !== 1'b0) begin bad++; $display("FAIL addi_req got=%0b want=0", dmem.dmem_req_valid); end
        @(negedge clk);
        total++; if (wb.valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b want=1", wb.valid); end
        total++; if (wb.result !== 32'h5) begin bad++; $display("FAIL addi_result got=%h want=00000005", wb.result); end
        total++; if (wb.rd !== 5'd3) begin bad++; $display("FAIL addi_rd got=%0d want=3", wb.rd); end
        ex.valid = 1'b0;
        @(negedge clk);
        total++; if (wb.valid !== 1'b0) begin bad++; $display("FAIL invalid_bubble got=%0b want=0", wb.valid); end
    endtask

    task automatic test_store();
        instr_name_e names[4]   = '{SB, SH, SW, SB};
        logic [31:0] alus[4]    = '{32'h0000_1003, 32'h0000_2002, 32'h0000_2004, 32'h0000_0010};
        logic [31:0] sds[4]     = '{32'h0000_00AB, 32'h1234_ABCD, 32'hCAFE_F00D, 32'h0000_005A};
        logic [3:0]  bes[4]     = '{4'b1000, 4'b1100, 4'b1111, 4'b0001};
        logic [31:0] wdatas[4]  = '{32'hABAB_ABAB, 32'hABCD_ABCD, 32'hCAFE_F00D, 32'h5A5A_5A5A};
        logic [31:0] addrs[4]   = '{32'h0000_1000, 32'h0000_2000, 32'h0000_2004, 32'h0000_0010};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_ex(names[i], alus[i], sds[i], 5'd0, 1'b0, 1'b0);
            set_mem(1'b1, 1'b0, 32'h0);
            #1;
            total++; if (dmem.dmem_be !== bes[i]) begin bad++; $display("FAIL store%0d_be got=%b want=%b", i, dmem.dmem_be, bes[i]); end
            total++; if (dmem.dmem_wdata !== wdatas[i]) begin bad++; $display("FAIL store%0d_wdata got=%h want=%h", i, dmem.dmem_wdata, wdatas[i]); end
            total++; if (dmem.dmem_addr !== addrs[i]) begin bad++; $display("FAIL store%0d_addr got=%h want=%h", i, dmem.dmem_addr, addrs[i]); end
            total++; if ({dmem.dmem_req_valid, dmem.dmem_we, stall_flag} !== 3'b110) begin bad++; $display("FAIL store%0d_req_we_stall got=%b want=110", i, {dmem.dmem_req_valid, dmem.dmem_we, stall_flag}); end
            @(negedge clk);
            total++; if ({wb.valid, wb.wbv} !== 2'b10) begin bad++; $display("FAIL store%0d_retire got=%b want=10", i, {wb.valid, wb.wbv}); end
            ex.valid = 1'b0;
            set_mem(1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic test_load_wait();
        int stalls = 0;
        int bubbles = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (wb.valid !== 1'b0) begin bad++; $display("FAIL lb_bubble%0d got=%0b want=0", i, wb.valid); end
                else bubbles++;
            end
            if (i == 0) set_ex(LB, 32'h0000_2001, 32'h0, 5'd7, 1'b1, 1'b1);
            set_mem(i == 2, i == 5, 32'h0000_8000);
            #1;
            total++; if (dmem.dmem_req_valid !== (i <= 2)) begin bad++; $display("FAIL lb_req%0d got=%0b want=%0b", i, dmem.dmem_req_valid, i <= 2); end
            if (stall_flag === 1'b1) stalls++;
        end
        @(negedge clk);
        total++; if (wb.valid !== 1'b1) begin bad++; $display("FAIL lb_valid got=%0b want=1", wb.valid); end
        total++; if (wb.result !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_result got=%h want=ffffff80", wb.result); end
        total++; if (wb.rd !== 5'd7) begin bad++; $display("FAIL lb_rd got=%0d want=7", wb.rd); end
        total++; if (stalls != 5) begin bad++; $display("FAIL lb_stall_cycles got=%0d want=5", stalls); end
        total++; if (bubbles != 5) begin bad++; $display("FAIL lb_bubbles got=%0d want=5", bubbles); end
        ex.valid = 1'b0;
        set_mem(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_load_format();
        instr_name_e names[5]  = '{LHU, LH, LBU, LW, LB};
        logic [31:0] alus[5]   = '{32'h0000_2002, 32'h0000_2000, 32'h0000_2003, 32'h0000_2008, 32'h0000_2002};
        logic [31:0] rdatas[5] = '{32'hBEEF_1234, 32'h0000_8001, 32'h9A00_0000, 32'h1122_3344, 32'h007F_0000};
        logic [31:0] exps[5]   = '{32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_009A, 32'h1122_3344, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_ex(names[i], alus[i], 32'h0, 5'd9, 1'b1, 1'b1);
            set_mem(1'b1, 1'b0, 32'h0);
            #1;
            total++; if ({stall_flag, dmem.dmem_we, dmem.dmem_be} !== 6'b10_1111) begin bad++; $display("FAIL ld%0d_issue got=%b want=101111", i, {stall_flag, dmem.dmem_we, dmem.dmem_be}); end
            @(negedge clk);
            set_mem(1'b0, 1'b1, rdatas[i]);
            total++; if (wb.valid !== 1'b0) begin bad++; $display("FAIL ld%0d_bubble got=%0b want=0", i, wb.valid); end
            #1;
            total++; if (stall_flag !== 1'b0) begin bad++; $display("FAIL ld%0d_rsp_stall got=%0b want=0", i, stall_flag); end
            @(negedge clk);
            total++; if (wb.valid !== 1'b1 || wb.result !== exps[i]) begin bad++; $display("FAIL ld%0d_result got=%0b/%h want=1/%h", i, wb.valid, wb.result, exps[i]); end
            ex.valid = 1'b0;
            set_mem(1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (c == 0) set_ex(LW, 32'h0000_4000, 32'h0, 5'd2, 1'b1, 1'b1);
            else begin
                total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL to_early_err%0d got=%0b want=0", c, mem_error); end
            end
            set_mem(1'b0, 1'b0, 32'h0);
            #1;
            total++; if (stall_flag !== (c < 16)) begin bad++; $display("FAIL to_stall%0d got=%0b want=%0b", c, stall_flag, c < 16); end
            if (c == 5) begin
                total++; if (dmem.dmem_req_valid !== 1'b1) begin bad++; $display("FAIL to_req_held got=%0b want=1", dmem.dmem_req_valid); end
            end
        end
        @(negedge clk);
        total++; if (mem_error !== 1'b1) begin bad++; $display("FAIL to_err got=%0b want=1", mem_error); end
        total++; if (wb.valid !== 1'b0) begin bad++; $display("FAIL to_bubble got=%0b want=0", wb.valid); end
        ex.valid = 1'b0;
        set_mem(1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        total++; if ({stall_flag, dmem.dmem_req_valid} !== 2'b00) begin bad++; $display("FAIL to_idle got=%b want=00", {stall_flag, dmem.dmem_req_valid}); end
        @(negedge clk);
        total++; if ({wb.valid, mem_error} !== 2'b00) begin bad++; $display("FAIL stray_rsp got=%b want=00", {wb.valid, mem_error}); end
        set_mem(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_misalign();
        @(negedge clk);
        set_ex(LW, 32'h0000_3002, 32'h0, 5'd4, 1'b1, 1'b1);
        set_mem(1'b1, 1'b0, 32'h0);
        #1;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        total++; if ({dmem.dmem_req_valid, stall_flag} !== 2'b00) begin bad++; $display("FAIL mis_noreq got=%b want=00", {dmem.dmem_req_valid, stall_flag}); end
        @(negedge clk);
        total++; if ({mem_error, wb.valid} !== 2'b10) begin bad++; $display("FAIL mis_err got=%b want=10", {mem_error, wb.valid}); end
`else
        total++; if ({dmem.dmem_req_valid, stall_flag} !== 2'b11) begin bad++; $display("FAIL mis_req got=%b want=11", {dmem.dmem_req_valid, stall_flag}); end
        total++; if (dmem.dmem_addr !== 32'h0000_3000) begin bad++; $display("FAIL mis_addr got=%h want=00003000", dmem.dmem_addr); end
        @(negedge clk);
        set_mem(1'b0, 1'b1, 32'h1122_3344);
        @(negedge clk);
        total++; if ({wb.valid, mem_error} !== 2'b10 || wb.result !== 32'h1122_3344) begin bad++; $display("FAIL mis_load got=%b/%h want=10/11223344", {wb.valid, mem_error}, wb.result); end
`endif
        ex.valid = 1'b0;
        set_mem(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        set_ex(LW, 32'h0000_5000, 32'h0, 5'd6, 1'b1, 1'b1);
        set_mem(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        set_mem(1'b0, 1'b0, 32'h0);
        #1;
        total++; if ({stall_flag, dmem.dmem_req_valid} !== 2'b10) begin bad++; $display("FAIL rw_wait got=%b want=10", {stall_flag, dmem.dmem_req_valid}); end
        reset = 1'b0;
        #1;
        total++; if ({stall_flag, dmem.dmem_req_valid, wb.valid} !== 3'b000) begin bad++; $display("FAIL rw_reset got=%b want=000", {stall_flag, dmem.dmem_req_valid, wb.valid}); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if ({stall_flag, dmem.dmem_req_valid} !== 2'b11) begin bad++; $display("FAIL rw_reissue got=%b want=11", {stall_flag, dmem.dmem_req_valid}); end
        set_mem(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        set_mem(1'b0, 1'b1, 32'h0000_0055);
        @(negedge clk);
        total++; if (wb.valid !== 1'b1 || wb.result !== 32'h55) begin bad++; $display("FAIL rw_after got=%0b/%h want=1/00000055", wb.valid, wb.result); end
        ex.valid = 1'b0;
        set_mem(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_nonmem();
        test_store();
        test_load_wait();
        test_load_format();
        test_timeout();
        test_misalign();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of the execute stage: consumes the `exmem_reg` bundle, performs loads and stores against a data-memory request/response port, and registers the `memwb_reg` bundle for writeback. A three-state FSM sequences each memory access. It stalls upstream while an access is outstanding, formats load data (byte/half extraction, sign/zero extension), generates store byte enables, and aborts accesses that exceed a wait-cycle limit.

## Interface
- `MAX_WAIT`, 16: cycles allowed in REQ+WAIT before timeout abort (≥2).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `EXMEM` in `exmem_reg`: execute-stage output (valid, alu_result, rd, wbv, decoded_instr_name, store_data, is_load, pc_plus_4, instruction).
- `MEMWB` out `memwb_reg`: registered writeback bundle (valid, rd, wbv, result, decoded_instr_name, pc_plus_4, instruction).
- `stall_flag` out 1: upstream must hold EXMEM stable this cycle.
- `dmem_req_valid` out 1: request valid.
- `dmem_req_ready` in 1: memory accepts the request this cycle.
- `dmem_addr` out 32: `{alu_result[31:2], 2'b00}`.
- `dmem_we` out 1: 1 for stores.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_rsp_valid` in 1: load data valid.
- `dmem_rdata` in 32: load data word.
- `mem_error` out 1: one-cycle pulse on timeout or misalignment, registered.

## Operation
- Memory op means EXMEM.valid and the instruction is LB/LH/LW/LBU/LHU/SB/SH/SW; off = alu_result[1:0].
- IDLE: non-memory valid instruction → MEMWB captures it next edge with result = alu_result; no stall. Invalid EXMEM → MEMWB.valid ← 0.
- IDLE with a memory op: drive dmem_req_valid combinationally from EXMEM. On ready, a store retires next edge with wbv=0 and stall=0, staying in IDLE; a load goes to WAIT with stall=1. On not-ready → REQ, stall=1.
- REQ: hold the request fields stable. On ready, a store retires and goes to IDLE with stall=0 that cycle; a load goes to WAIT with stall=1.
- WAIT: dmem_req_valid=0, stall=1 until dmem_rsp_valid. On rsp, MEMWB captures the formatted load with stall=0, then → IDLE.
- MEMWB.valid ← 0 on every stalled cycle (bubble).
- Timeout: counter clears on entering REQ/WAIT and increments each cycle there. When it equals MAX_WAIT−1 with no completing handshake, the FSM pulses mem_error, emits a bubble, sets stall=0 (instruction dropped) and goes → IDLE. A dmem_rsp_valid arriving in IDLE is ignored.
- Load format:
  - LB/LBU: byte `rdata[8*off+:8]`, sign- or zero-extended.
  - LH/LHU: half `rdata[16*off[1]+:16]`.
  - LW: full word.
- Store enables:
  - SB: be = 4'b0001<<off, wdata = {4{byte}}.
  - SH: be = 4'b0011<<(2*off[1]), wdata = {2{half}}.
  - SW: be = 4'hF.
  - Loads: be = 4'hF, we=0.

## Timing
- Reset (asserted low, async): state IDLE, counter 0, all MEMWB fields 0, mem_error 0. While asserted, dmem_req_valid=0 and stall_flag=0. Reset during REQ/WAIT abandons the access.
- Non-memory and zero-wait-store latency: 1 cycle, EXMEM→MEMWB.
- Load latency: 1 + accept wait + response wait cycles. Minimum is 2 (ready in IDLE, rsp the next cycle).
- Ready and rsp in the same WAIT-entry cycle is not possible; rsp is sampled only in WAIT.
- Stall and the stage outputs are combinational from the state and handshake inputs; MEMWB and mem_error are registered.

## Configuration
- `MEM_STAGE_MISALIGN_CHECK_EN` defined:
  - A misaligned access is LH/LHU/SH with off[0]=1, or LW/SW with off≠0.
  - Such an access issues no request: mem_error pulses, MEMWB.valid ← 0, stall=0, state stays IDLE.
- Undefined: no check. Half accesses ignore off[0]; word accesses ignore off[1:0].

## Structure
- Shared package `rv32i_types`:
  - `memwb_reg` struct.
  - `mem_state_e` enum {IDLE, REQ, WAIT}.
  - Existing `word`, `exmem_reg` and instruction-name enum.
- Sub-module `load_store_align` (combinational): inputs are the instruction name, off, store_data and rdata; outputs are be, wdata, load_result, misaligned.

## Test plan
- ADDI result 0x5 in EXMEM, non-memory → MEMWB.result=0x5 and valid the next cycle, stall never asserted.
- SB at addr 0x1003, store_data 0xAB, ready=1 → be=4'b1000, wdata=0xABABABAB, dmem_addr=0x1000, MEMWB.wbv=0.
- LB at 0x2001, ready held 0 for 2 cycles, rsp after 3 WAIT cycles with rdata 0x0000_8000 → result 0xFFFF_FF80. stall high for 5 cycles, 5 bubbles emitted.
- LHU at 0x2002, rdata 0xBEEF_1234 → result 0x0000_BEEF.
- LW with no response and MAX_WAIT=16 → mem_error pulses after 16 REQ+WAIT cycles, MEMWB.valid=0, returns to IDLE. A later stray rsp is ignored.
- Macro defined, LW at 0x3002 → no dmem_req_valid, mem_error pulse, MEMWB.valid=0. Reset asserted mid-WAIT → MEMWB.valid=0, state IDLE immediately.
